// File: rtl/hermes_buffer.sv
// hermes_buffer: Hermes NoC input buffer. It is a FIFO with a route/forward controller for each packet.
// Optional packet counter on pkt_cnt_o when HERMES_BUFFER_STATS_EN is defined.
module hermes_buffer #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           rx_i,
  input  logic                           eop_i,
  input  logic [FLIT_SIZE-1:0]           data_i,
  output logic                           credit_o,
  output logic                           req_o,
  input  logic                           ack_route_i,
  output logic                           tx_o,
  output logic                           eop_o,
  output logic [FLIT_SIZE-1:0]           data_o,
  input  logic                           credit_i,
  output logic [$clog2(BUFFER_SIZE):0]   occupancy_o,
  output logic [31:0]                    pkt_cnt_o
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(BUFFER_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_FWD} state_t;

  logic [FLIT_SIZE:0] r_mem [BUFFER_SIZE];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [OW-1:0]      r_occ;
  state_t             r_state, w_next;
  logic               w_wr, w_rd, w_nempty;
  logic [FLIT_SIZE:0] w_head;

  assign w_nempty    = r_occ != '0;
  assign w_head      = r_mem[r_rd_ptr];
  assign credit_o    = r_occ != FULL;
  assign w_wr        = rx_i && credit_o;
  assign w_rd        = tx_o && credit_i;
  assign occupancy_o = r_occ;

  // Storage needs no reset: occupancy gates everything read from it
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= {eop_i, data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_occ <= r_occ + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_nempty ? S_ROUTE : S_IDLE;
      S_ROUTE: w_next = ack_route_i ? S_FWD : S_ROUTE;
      S_FWD:   w_next = (w_rd && w_head[FLIT_SIZE]) ? S_IDLE : S_FWD;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_o  = r_state == S_ROUTE;
    tx_o   = (r_state == S_FWD) && w_nempty;
    eop_o  = tx_o && w_head[FLIT_SIZE];
    data_o = w_nempty ? w_head[FLIT_SIZE-1:0] : '0;
  end

`ifdef HERMES_BUFFER_STATS_EN
  logic [31:0] r_pkt_cnt;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      r_pkt_cnt <= '0;
    else if (w_rd && w_head[FLIT_SIZE]) r_pkt_cnt <= r_pkt_cnt + 32'd1;
  end
  assign pkt_cnt_o = r_pkt_cnt;
`else
  assign pkt_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hermes_buffer.sv
// tb_hermes_buffer: directed and random checks of hermes_buffer against a queue-based reference model.
module tb_hermes_buffer;
  localparam int DEPTH = 8;
  localparam int P_IDLE = 0, P_ROUTE = 1, P_FWD = 2;

  logic        clk_i = 0, rst_ni = 0, rx_i = 0, eop_i = 0, ack_route_i = 0, credit_i = 0;
  logic [31:0] data_i = '0;
  logic        credit_o, req_o, tx_o, eop_o;
  logic [31:0] data_o, pkt_cnt_o;
  logic [3:0]  occupancy_o;

  hermes_buffer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .eop_i(eop_i), .data_i(data_i),
    .credit_o(credit_o), .req_o(req_o), .ack_route_i(ack_route_i), .tx_o(tx_o),
    .eop_o(eop_o), .data_o(data_o), .credit_i(credit_i), .occupancy_o(occupancy_o),
    .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;
  logic [32:0] q[$];
  int          ph = P_IDLE;
  logic [31:0] m_pkts = 0;
  logic        o_req, o_tx, o_eop;
  logic [31:0] o_data;
  logic        o_took;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef HERMES_BUFFER_STATS_EN
    return m_pkts;
`else
    return 32'd0;
`endif
  endfunction

  task automatic cycle(input logic rx, input logic e, input logic [31:0] d,
                       input logic ack, input logic cr);
    int n;
    logic etx, ehe, rd, wr;
    rx_i = rx; eop_i = e; data_i = d; ack_route_i = ack; credit_i = cr;
    #1;
    n   = q.size();
    ehe = (n != 0) ? q[0][32] : 1'b0;
    etx = (ph == P_FWD) && (n != 0);
    check("occupancy", 64'(occupancy_o), 64'(n));
    check("credit_o", 64'(credit_o), 64'(n != DEPTH));
    check("req_o", 64'(req_o), 64'(ph == P_ROUTE));
    check("tx_o", 64'(tx_o), 64'(etx));
    check("eop_o", 64'(eop_o), 64'(etx && ehe));
    check("data_o", 64'(data_o), (n != 0) ? 64'(q[0][31:0]) : 64'd0);
    check("pkt_cnt", 64'(pkt_cnt_o), 64'(exp_cnt()));
    o_req = req_o; o_tx = tx_o; o_eop = eop_o; o_data = data_o;
    rd = etx && cr;
    wr = rx && (n != DEPTH);
    o_took = rd;
    if (ph == P_IDLE && n != 0)  ph = P_ROUTE;
    else if (ph == P_ROUTE && ack) ph = P_FWD;
    else if (ph == P_FWD && rd && ehe) ph = P_IDLE;
    if (rd) begin
      void'(q.pop_front());
      if (ehe) m_pkts++;
    end
    if (wr) q.push_back({e, d});
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_credit"}, 64'(credit_o), 64'd1);
    check({tag, "_req"}, 64'(req_o), 64'd0);
    check({tag, "_tx"}, 64'(tx_o), 64'd0);
    check({tag, "_eop"}, 64'(eop_o), 64'd0);
    check({tag, "_data"}, 64'(data_o), 64'd0);
    check({tag, "_occ"}, 64'(occupancy_o), 64'd0);
    check({tag, "_pkt"}, 64'(pkt_cnt_o), 64'd0);
  endtask

  task automatic do_reset();
    rx_i = 0; ack_route_i = 0; credit_i = 0;
    rst_ni = 0;
    #2;
    check_reset_values("reset");
    q.delete(); ph = P_IDLE; m_pkts = 0;
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int nreq, ntx, neop;
    logic [31:0] got[$];
    logic [31:0] req_data[$];
    #1;
    check_reset_values("init");
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;

    // 4-flit packet, grant always offered (ignored outside ROUTE)
    nreq = 0; ntx = 0; neop = 0; got.delete();
    for (int k = 0; k < 14; k++) begin
      cycle(k < 4, k == 3, 32'hA0 + 32'(k), 1'b1, 1'b1);
      if (o_req) nreq++;
      if (o_tx) begin ntx++; got.push_back(o_data); end
      if (o_eop) begin neop++; check("pkt4_eop_data", 64'(o_data), 64'hA3); end
    end
    check("pkt4_req_cycles", 64'(nreq), 64'd1);
    check("pkt4_tx_cycles", 64'(ntx), 64'd4);
    check("pkt4_eop_count", 64'(neop), 64'd1);
    for (int k = 0; k < 4; k++)
      check("pkt4_data_seq", (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'hA0 + 64'(k));

    // Fill to full with downstream blocked; the 9th flit must be refused
    for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
    check("full_credit", 64'(credit_o), 64'd0);
    check("full_occ", 64'(occupancy_o), 64'd8);
    cycle(1'b1, 1'b1, 32'h108, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h108, 1'b0, 1'b1);
    check("full_single_read", 64'(o_took), 64'd1);
    check("full_credit_back", 64'(credit_o), 64'd1);
    for (int k = 0; k < 40 && q.size() != 0; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("full_drained", 64'(occupancy_o), 64'd0);

    // Single-flit packet followed by a 2-flit packet
    req_data.delete(); nreq = 0;
    for (int k = 0; k < 14; k++) begin
      cycle(k < 3, k != 1, (k == 0) ? 32'h55 : (k == 1) ? 32'h66 : 32'h77, 1'b1, 1'b1);
      if (o_req) begin nreq++; req_data.push_back(o_data); end
    end
    check("two_pkt_req_count", 64'(nreq), 64'd2);
    check("two_pkt_req2_data", (req_data.size() > 1) ? 64'(req_data[1]) : 64'hDEAD, 64'h66);

    // Downstream credit toggling mid-packet
    got.delete();
    for (int k = 0; k < 16; k++) begin
      cycle(k < 4, k == 3, 32'hB0 + 32'(k), 1'b1, (k % 3) != 1);
      if (o_took) got.push_back(o_data);
    end
    check("toggle_count", 64'(got.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      check("toggle_seq", (k < got.size()) ? 64'(got[k]) : 64'hDEAD, 64'hB0 + 64'(k));

    // Reset in FORWARD with 3 flits stored
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 32'hC0 + 32'(k), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_tx", 64'(o_tx), 64'd1);
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Randomised traffic, then drain
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom % 2), ($urandom % 4) == 0, $urandom, 1'($urandom % 2), ($urandom % 4) != 0);
    cycle(1'b1, 1'b1, 32'hEE, 1'b1, 1'b1);
    for (int k = 0; k < 300 && q.size() != 0; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("final_occ", 64'(occupancy_o), 64'd0);
    check("final_pkt_cnt", 64'(pkt_cnt_o), 64'(exp_cnt()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hermes_buffer.md
HERMES_BUFFER -- requirements
Module: hermes_buffer

Interface
REQ-001 The block SHALL have parameter FLIT_SIZE, default 32, meaning the flit data width in bits.
REQ-002 The block SHALL have parameter BUFFER_SIZE, default 8, meaning FIFO depth in flits, a power of two and at least 2.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 rx_i  input  1  upstream flit valid.
REQ-007 eop_i  input  1  upstream flit is the last flit of its packet.
REQ-008 data_i  input  FLIT_SIZE  upstream flit data.
REQ-009 credit_o  output  1  buffer can accept a flit this cycle.
REQ-010 req_o  output  1  routing request for the packet whose header is at the FIFO head.
REQ-011 ack_route_i  input  1  routing granted; forwarding may start.
REQ-012 tx_o  output  1  downstream flit valid.
REQ-013 eop_o  output  1  downstream flit is the last flit of its packet.
REQ-014 data_o  output  FLIT_SIZE  downstream flit data, the FIFO head.
REQ-015 credit_i  input  1  downstream accepts a flit this cycle.
REQ-016 occupancy_o  output  $clog2(BUFFER_SIZE)+1  number of stored flits.
REQ-017 pkt_cnt_o  output  32  packets forwarded; only valid when the stats feature is enabled.

Function
REQ-018 A write SHALL occur when rx_i && credit_o; credit_o SHALL be (occupancy != BUFFER_SIZE), independent of rx_i.
REQ-019 Each entry SHALL store {eop_i, data_i}, FLIT_SIZE+1 bits.
REQ-020 A read SHALL occur when tx_o && credit_i.
REQ-021 Read and write pointers SHALL wrap modulo BUFFER_SIZE.
REQ-022 A simultaneous read and write SHALL leave occupancy unchanged.
REQ-023 rx_i while full SHALL be ignored with no state change; upstream holds the flit until credit_o.
REQ-024 A written flit SHALL become visible at the head no earlier than the next cycle; there is no bypass, so the minimum rx-to-tx latency is 1 cycle.
REQ-025 data_o SHALL present the head entry when occupancy != 0, and all-zero when the FIFO is empty.
REQ-026 The control FSM SHALL have three states: IDLE, ROUTE and FORWARD.
REQ-027 In IDLE, the FSM SHALL move to ROUTE when occupancy != 0.
REQ-028 In ROUTE, req_o SHALL be 1 and the FSM SHALL move to FORWARD on ack_route_i, otherwise hold.
REQ-029 req_o SHALL be 0 in IDLE and FORWARD.
REQ-030 In FORWARD, tx_o SHALL be (occupancy != 0); tx_o SHALL be 0 in IDLE and ROUTE.
REQ-031 eop_o SHALL be tx_o && the head entry's eop bit.
REQ-032 In FORWARD, a read of a flit with eop set SHALL return the FSM to IDLE.
REQ-033 When flits of the next packet remain after the return to IDLE, the FSM SHALL enter ROUTE on the following cycle; a new packet always costs at least one ROUTE cycle.
REQ-034 A single-flit packet (header with eop) SHALL be forwarded and return the FSM to IDLE on its read.
REQ-035 Writes SHALL continue in every FSM state, including while waiting in ROUTE.
REQ-036 ack_route_i outside ROUTE SHALL be ignored.
REQ-037 If credit_i drops mid-packet, the FSM SHALL stay in FORWARD and the head SHALL be held unchanged.

Reset
REQ-038 On rst_ni low, pointers and occupancy SHALL clear and the FSM SHALL enter IDLE.
REQ-039 Reset values SHALL be: credit_o=1, req_o=0, tx_o=0, eop_o=0, data_o=0, occupancy_o=0, pkt_cnt_o=0.
REQ-040 Reset mid-packet SHALL discard all stored flits, with no partial-packet recovery.
REQ-041 Storage contents SHALL need no reset.

Configuration
REQ-042 With HERMES_BUFFER_STATS_EN defined, pkt_cnt_o SHALL increment by 1 on each read with eop set, wrapping 2^32-1 to 0.
REQ-043 Without HERMES_BUFFER_STATS_EN, the pkt_cnt_o port SHALL exist, be tied to 0, and no counter logic SHALL be present.

Verification
REQ-044 Bench: 4-flit packet 0xA0..0xA3 (eop on 0xA3), ack_route_i one cycle after req_o, credit_i=1 -> req_o 1 cycle; tx_o 4 cycles with data 0xA0..0xA3; eop_o only with 0xA3; FSM returns to IDLE.
REQ-045 Bench: credit_i=0, 8 consecutive writes -> credit_o=0 after the 8th write, occupancy_o=8, 9th flit held and not written; one read -> credit_o=1 next cycle.
REQ-046 Bench: single-flit packet 0x55 with eop, then 2-flit packet 0x66,0x77 -> two separate req_o assertions; the second req_o has data_o=0x66.
REQ-047 Bench: credit_i toggled 1,0,1 mid-packet -> no flit lost or duplicated; data_o stable while credit_i=0.
REQ-048 Bench: rst_ni pulsed low with 3 flits stored in FORWARD -> all outputs at reset values; occupancy_o=0.
REQ-049 Bench: with HERMES_BUFFER_STATS_EN, 3 packets forwarded -> pkt_cnt_o=3; without the macro -> pkt_cnt_o=0 throughout.
